// File: rtl/lift_controller_n.sv
// N-floor SCAN lift controller: latched hall calls, sensor-tracked position, door dwell, motor drive.
// Define LIFT_IDLE_HOME_EN to return the car to floor 0 after IDLE_HOME idle cycles.

module lift_call_latch (
  input  logic clock,
  input  logic n_reset,
  input  logic press_n,
  input  logic clr,
  output logic pend,
  output logic eff
);
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset)      pend <= 1'b0;
    else if (clr)      pend <= 1'b0;
    else if (!press_n) pend <= 1'b1;

  // Scheduling view: a press counts in the very cycle it is seen, unless this floor is dwelling.
  assign eff = !clr && (pend || !press_n);
endmodule

module lift_controller_n #(
  parameter  int FLOORS    = 4,
  parameter  int DWELL     = 50000000,
  parameter  int IDLE_HOME = 500000000,
  localparam int FW        = $clog2(FLOORS)
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [FLOORS-1:0] floor_n,
  input  logic [FLOORS-1:0] call_n,
  output logic              direction,
  output logic              enable,
  output logic [FLOORS-1:0] indicator,
  output logic [FW-1:0]     cur_floor,
  output logic [2:0]        state_code
);
  localparam int DCW = $clog2(DWELL + 1);
  localparam int ICW = $clog2(IDLE_HOME + 1);
  localparam int CW  = (DCW > ICW) ? DCW : ICW;

  typedef enum logic [2:0] {
    S_HOMING = 3'd0,
    S_IDLE   = 3'd1,
    S_DWELL  = 3'd2,
    S_UP     = 3'd3,
    S_DOWN   = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              dir, dir_nx;
  logic [FW-1:0]     cur_nx;
  logic [CW-1:0]     tmr, tmr_nx;
  logic [FLOORS-1:0] pend, eff, clr;
  logic              hit;
  logic [FW-1:0]     k;
  logic              above, below, beyond_up, beyond_dn;
  logic              go_up, go_dn;
  logic              run_on;

  function automatic logic any_in(input logic [FLOORS-1:0] m, input logic [FW-1:0] pos,
                                  input logic up);
    any_in = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (m[i] && (up ? (i > int'(pos)) : (i < int'(pos)))) any_in = 1'b1;
  endfunction

  for (genvar g = 0; g < FLOORS; g++) begin : g_call
    assign clr[g] = (state == S_DWELL) && (cur_floor == FW'(g));
    lift_call_latch u_call (
      .clock   (clock),
      .n_reset (n_reset),
      .press_n (call_n[g]),
      .clr     (clr[g]),
      .pend    (pend[g]),
      .eff     (eff[g])
    );
  end

  // Lowest active sensor wins if several are (illegally) active.
  always_comb begin
    hit = 1'b0;
    k   = '0;
    for (int i = FLOORS - 1; i >= 0; i--)
      if (!floor_n[i]) begin
        hit = 1'b1;
        k   = FW'(i);
      end
  end

  assign above     = any_in(eff, cur_floor, 1'b1);
  assign below     = any_in(eff, cur_floor, 1'b0);
  assign beyond_up = any_in(eff, k, 1'b1);
  assign beyond_dn = any_in(eff, k, 1'b0);
  assign go_up     = above && (dir || !below);
  assign go_dn     = !go_up && below;

`ifdef LIFT_IDLE_HOME_EN
  logic home_run, home_nx;
  assign run_on = home_run;
`else
  assign run_on = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    cur_nx   = cur_floor;
    tmr_nx   = '0;
    enable   = 1'b1;
`ifdef LIFT_IDLE_HOME_EN
    home_nx  = home_run;
`endif
    case (state)
      S_HOMING: begin
        dir_nx = 1'b0;
        enable = !floor_n[0];
        if (!floor_n[0]) begin
          cur_nx   = '0;
          state_nx = S_IDLE;
        end
      end
      S_IDLE: begin
        if (eff[cur_floor]) state_nx = S_DWELL;
        else if (go_up) begin
          state_nx = S_UP;
          dir_nx   = 1'b1;
        end else if (go_dn) begin
          state_nx = S_DOWN;
          dir_nx   = 1'b0;
        end
`ifdef LIFT_IDLE_HOME_EN
        else if (cur_floor != '0) begin
          if (tmr == CW'(IDLE_HOME - 1)) begin
            state_nx = S_DOWN;
            dir_nx   = 1'b0;
            home_nx  = 1'b1;
          end else tmr_nx = tmr + 1'b1;
        end
`endif
      end
      S_DWELL: begin
        // Own-floor call is already masked out of eff, so this is the plain departure rule.
        if (tmr == CW'(DWELL - 1)) begin
          if (go_up) begin
            state_nx = S_UP;
            dir_nx   = 1'b1;
          end else if (go_dn) begin
            state_nx = S_DOWN;
            dir_nx   = 1'b0;
          end else state_nx = S_IDLE;
        end else tmr_nx = tmr + 1'b1;
      end
      S_UP: begin
        enable = 1'b0;
        if (hit && k != cur_floor) begin
          cur_nx = k;
          if (eff[k] || k == FW'(FLOORS - 1) || !beyond_up) begin
            enable   = 1'b1;
            state_nx = eff[k] ? S_DWELL : S_IDLE;
          end
        end
      end
      S_DOWN: begin
        enable = 1'b0;
        if (hit && k != cur_floor) begin
          cur_nx = k;
          // A return-to-ground run ignores the empty-below rule and only stops at 0 or a call.
          if (eff[k] || k == '0 || (!run_on && !beyond_dn)) begin
            enable   = 1'b1;
            state_nx = eff[k] ? S_DWELL : S_IDLE;
`ifdef LIFT_IDLE_HOME_EN
            home_nx  = 1'b0;
`endif
          end
        end
      end
      default: state_nx = S_HOMING;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      state     <= S_HOMING;
      dir       <= 1'b0;
      cur_floor <= '0;
      tmr       <= '0;
    end else begin
      state     <= state_nx;
      dir       <= dir_nx;
      cur_floor <= cur_nx;
      tmr       <= tmr_nx;
    end

`ifdef LIFT_IDLE_HOME_EN
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) home_run <= 1'b0;
    else          home_run <= home_nx;
`endif

  assign direction  = dir;
  assign indicator  = ~pend;
  assign state_code = state;
endmodule
